reg_dump_controller: RTL

//  Sequences a full dump of the 32x32 register file to the debug unit's byte-serial TX path.

---
 rtl/reg_dump_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/reg_dump_controller.sv
// Register-file dump sequencer: borrows read port 1, streams every register LSB-first
// as bytes to the TX wrapper, and holds the pipeline stalled while it does so.
module reg_dump_controller #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cpu_rd_addr1,
    output logic [ADDR_W-1:0] rf_rd_addr1,
    input  logic [DATA_W-1:0] rf_rd_data1,
    output logic              stall,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam int BYTES  = DATA_W / 8;
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [1:0]        LAST_WAIT = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   reg_cnt_q, reg_cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]          wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                busy_q, busy_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                done_q, done_d;

    // Next-state logic; outputs are decoded from the next state so they can be registered.
    always_comb begin
        state_d    = state_q;
        reg_cnt_d  = reg_cnt_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ADDR;
                    reg_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                state_d    = S_WAIT;
                wait_cnt_d = 2'd0;
            end
            S_WAIT: begin
                if (wait_cnt_q == LAST_WAIT) begin
                    shift_d    = rf_rd_data1;
                    byte_cnt_d = '0;
                    state_d    = S_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    shift_d    = shift_q >> 8;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (byte_cnt_q == LAST_BYTE) begin
                        if (reg_cnt_q < LAST_REG) begin
                            reg_cnt_d = reg_cnt_q + ADDR_W'(1);
                            state_d   = S_ADDR;
                        end else begin
                            state_d = S_FIN;
                        end
                    end else begin
                        state_d = S_SEND;
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
            S_FIN: begin
                // start is deliberately not looked at here
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d == S_ADDR) || (state_d == S_WAIT) || (state_d == S_SEND);
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = tx_valid_d ? shift_d[7:0] : 8'h00;
        done_d     = (state_d == S_FIN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            reg_cnt_q  <= '0;
            byte_cnt_q <= '0;
            wait_cnt_q <= 2'd0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_cnt_q  <= reg_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            shift_q    <= shift_d;
            busy_q     <= busy_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
        end
    end

    // Pipeline owns the read port only while idle.
    always_comb begin
        if (state_q == S_IDLE) begin
            rf_rd_addr1 = cpu_rd_addr1;
        end else begin
            rf_rd_addr1 = reg_cnt_q;
        end
    end

    assign busy     = busy_q;
    assign stall    = busy_q;
    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;

endmodule
